// File: rtl/noc_traffic_gen_if.sv
// Local-port injection bundle between a traffic generator and its NoC node.
// The master presents a packet; the slave returns the local-port enable.
interface noc_traffic_gen_if #(
    parameter int DEST_W    = 4,
    parameter int SEQ_W     = 8,
    parameter int PAYLOAD_W = 16
) ();
    logic                 o_data_val;
    logic                 i_en;
    logic [DEST_W-1:0]    o_dest;
    logic [DEST_W-1:0]    o_src;
    logic [SEQ_W-1:0]     o_seq;
    logic [PAYLOAD_W-1:0] o_payload;

    modport master (
        output o_data_val,
        output o_dest,
        output o_src,
        output o_seq,
        output o_payload,
        input  i_en
    );

    modport slave (
        input  o_data_val,
        input  o_dest,
        input  o_src,
        input  o_seq,
        input  o_payload,
        output i_en
    );
endinterface

// File: rtl/noc_traffic_gen.sv
// Per-node synthetic packet injector: LFSR destinations/payloads, sequence
// numbers, programmable inter-packet gap and a fixed packet count per run.
module noc_traffic_gen #(
    parameter int NODES      = 16,
    parameter int NODE_ID    = 0,
    parameter int SEQ_W      = 8,
    parameter int PAYLOAD_W  = 16,
    parameter int INJ_PERIOD = 64,
    parameter int MAX_PKTS   = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    noc_traffic_gen_if.master nif,
    output logic [15:0]       o_sent,
    output logic [15:0]       o_stall,
    output logic              o_done
);
    localparam int DEST_W = $clog2(NODES);
    localparam int GAP_W  = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD + 1) : 1;
    localparam logic [15:0]       SEED   = {8'hA5, 8'(NODE_ID)} | 16'h0001;
    localparam logic [DEST_W-1:0] SELF   = DEST_W'(NODE_ID);
    localparam logic [GAP_W-1:0]  GAP_LD = GAP_W'(INJ_PERIOD);
    localparam logic [15:0]       LAST   = 16'(MAX_PKTS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [GAP_W-1:0]   gap, gap_nxt;
    logic [15:0]        lfsr, lfsr_nxt;
    logic [DEST_W-1:0]  dest;
    logic [SEQ_W-1:0]   seq;
    logic [15:0]        sent;
    logic [15:0]        stall;
    logic               val;
    logic               done;
    logic               clr;
    logic               xfer;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Bumping a self-hit to the next node keeps the map total and cheap.
    function automatic logic [DEST_W-1:0] pick_dest(input logic [15:0] l);
        logic [DEST_W-1:0] c;
        c = l[15 -: DEST_W];
        return (c == SELF) ? c + 1'b1 : c;
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        clr       = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    clr       = 1'b1;
                    gap_nxt   = GAP_LD;
                    state_nxt = (INJ_PERIOD == 0) ? SEND : WAIT;
                end
            end
            WAIT: begin
                if (gap <= GAP_W'(1)) begin
                    state_nxt = SEND;
                end else begin
                    gap_nxt = gap - 1'b1;
                end
            end
            SEND: begin
                if (nif.i_en) begin
                    xfer    = 1'b1;
                    gap_nxt = GAP_LD;
                    if (sent + 16'd1 == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = (INJ_PERIOD == 0) ? SEND : WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gap   <= '0;
            lfsr  <= SEED;
            dest  <= pick_dest(SEED);
            seq   <= '0;
            sent  <= '0;
            stall <= '0;
            val   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
            val   <= (state_nxt == SEND);
            done  <= (state_nxt == DONE);
            if (clr) begin
                seq   <= '0;
                sent  <= '0;
                stall <= '0;
            end else if (xfer) begin
                seq  <= seq + 1'b1;
                sent <= sent + 16'd1;
                lfsr <= lfsr_nxt;
                dest <= pick_dest(lfsr_nxt);
            end
            if (state == SEND && !nif.i_en && stall != 16'hFFFF) begin
                stall <= stall + 16'd1;
            end
        end
    end

    assign nif.o_data_val = val;
    assign nif.o_dest     = dest;
    assign nif.o_src      = SELF;
    assign nif.o_seq      = seq;
    assign nif.o_payload  = lfsr[PAYLOAD_W-1:0];
    assign o_sent         = sent;
    assign o_stall        = stall;
    assign o_done         = done;
endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench: reset, gap/latency, ignored start, backpressure,
// self-avoidance sweep and sequence wrap with restart.
module tb_noc_traffic_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int checks = 0;
    int failures = 0;

    logic start_a, start_b, start_c, start_d;
    logic done_a, done_b, done_d;
    logic [15:0] sent_a, stall_a, sent_b, stall_b, sent_d, stall_d;
    logic en_c;
    logic [3:0] c_done, c_val;
    logic [1:0] c_dest [4];
    logic [15:0] c_sent [4];
    logic [3:0] hits [4];

    logic [15:0] la, ld;
    int pk;

    noc_traffic_gen_if #(.DEST_W(4), .SEQ_W(8), .PAYLOAD_W(16)) ifa ();
    noc_traffic_gen_if #(.DEST_W(4), .SEQ_W(8), .PAYLOAD_W(16)) ifb ();
    noc_traffic_gen_if #(.DEST_W(4), .SEQ_W(4), .PAYLOAD_W(16)) ifd ();

    noc_traffic_gen #(
        .NODES(16), .NODE_ID(3), .SEQ_W(8), .PAYLOAD_W(16),
        .INJ_PERIOD(4), .MAX_PKTS(3)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .i_start(start_a), .nif(ifa.master),
        .o_sent(sent_a), .o_stall(stall_a), .o_done(done_a)
    );

    noc_traffic_gen #(
        .NODES(16), .NODE_ID(7), .SEQ_W(8), .PAYLOAD_W(16),
        .INJ_PERIOD(0), .MAX_PKTS(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .i_start(start_b), .nif(ifb.master),
        .o_sent(sent_b), .o_stall(stall_b), .o_done(done_b)
    );

    noc_traffic_gen #(
        .NODES(16), .NODE_ID(5), .SEQ_W(4), .PAYLOAD_W(16),
        .INJ_PERIOD(0), .MAX_PKTS(20)
    ) u_d (
        .clk(clk), .reset_n(reset_n), .i_start(start_d), .nif(ifd.master),
        .o_sent(sent_d), .o_stall(stall_d), .o_done(done_d)
    );

    for (genvar g = 0; g < 4; g++) begin : g_c
        noc_traffic_gen_if #(.DEST_W(2), .SEQ_W(8), .PAYLOAD_W(16)) ifc ();
        logic [15:0] s_stall;
        assign ifc.i_en  = en_c;
        assign c_val[g]  = ifc.o_data_val;
        assign c_dest[g] = ifc.o_dest;
        noc_traffic_gen #(
            .NODES(4), .NODE_ID(g), .SEQ_W(8), .PAYLOAD_W(16),
            .INJ_PERIOD(0), .MAX_PKTS(1000)
        ) u_c (
            .clk(clk), .reset_n(reset_n), .i_start(start_c), .nif(ifc.master),
            .o_sent(c_sent[g]), .o_stall(s_stall), .o_done(c_done[g])
        );
    end

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [3:0] dmod16(input logic [15:0] l, input int id);
        logic [3:0] c;
        c = l[15:12];
        if (c == 4'(id)) c = c + 4'd1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a run on u_a and follow it for 17 observations after the start edge.
    task automatic run_a(input bit pulse);
        logic exp_v;
        pk = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            exp_v = (k == 4 || k == 9 || k == 14);
            check("a_val", ifa.o_data_val, exp_v);
            check("a_done", done_a, k >= 15);
            if (exp_v) begin
                check("a_seq", ifa.o_seq, pk);
                check("a_pay", ifa.o_payload, la);
                check("a_dest", ifa.o_dest, dmod16(la, 3));
                la = lstep(la);
                pk++;
            end
            if (pulse) start_a = (k == 1 || k == 4);
            @(negedge clk);
        end
        check("a_sent", sent_a, 3);
        check("a_stall", stall_a, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        ifa.i_en = 1'b0;
        ifb.i_en = 1'b0;
        ifd.i_en = 1'b0;
        en_c = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_val", ifa.o_data_val, 0);
        check("rst_done", done_a, 0);
        check("rst_sent", sent_a, 0);
        check("rst_stall", stall_a, 0);
        check("rst_seq", ifa.o_seq, 0);
        check("rst_pay", ifa.o_payload, 16'hA503);
        check("rst_src", ifa.o_src, 3);
        check("rst_dest", ifa.o_dest, 10);

        ifa.i_en = 1'b1;
        la = 16'hA503;
        run_a(1'b0);
        run_a(1'b1);

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_val", ifa.o_data_val, 1);
        check("mid_sent", sent_a, 1);
        reset_n = 1'b0;
        #1;
        check("rr_val", ifa.o_data_val, 0);
        check("rr_sent", sent_a, 0);
        check("rr_seq", ifa.o_seq, 0);
        check("rr_done", done_a, 0);
        check("rr_pay", ifa.o_payload, 16'hA503);
        check("rr_dest", ifa.o_dest, 10);
        check("rr_src", ifa.o_src, 3);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rr_hold", ifa.o_data_val, 0);

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("b_val", ifb.o_data_val, 1);
            check("b_seq", ifb.o_seq, 0);
            check("b_pay", ifb.o_payload, 16'hA507);
            check("b_dest", ifb.o_dest, 10);
            @(negedge clk);
        end
        check("b_stall7", stall_b, 7);
        check("b_seq7", ifb.o_seq, 0);
        ifb.i_en = 1'b1;
        @(negedge clk);
        check("b_val8", ifb.o_data_val, 1);
        check("b_seq8", ifb.o_seq, 1);
        check("b_pay8", ifb.o_payload, lstep(16'hA507));
        check("b_sent8", sent_b, 1);
        @(negedge clk);
        check("b_done", done_b, 1);
        check("b_valdn", ifb.o_data_val, 0);
        check("b_sent", sent_b, 2);
        check("b_stall", stall_b, 7);

        for (int g = 0; g < 4; g++) hits[g] = 4'b0;
        en_c = 1'b1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int n = 0; n < 1100 && c_done != 4'hF; n++) begin
            for (int g = 0; g < 4; g++) begin
                if (c_val[g]) begin
                    check("c_self", c_dest[g] != 2'(g), 1);
                    hits[g][c_dest[g]] = 1'b1;
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < 4; g++) begin
            check("c_done", c_done[g], 1);
            check("c_sent", c_sent[g], 1000);
            check("c_hits", hits[g], 4'hF & ~(4'b1 << g));
        end

        ifd.i_en = 1'b1;
        ld = 16'hA505;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("d_val", ifd.o_data_val, 1);
            check("d_seq", ifd.o_seq, k % 16);
            check("d_pay", ifd.o_payload, ld);
            ld = lstep(ld);
            @(negedge clk);
        end
        check("d_done", done_d, 1);
        check("d_valdn", ifd.o_data_val, 0);
        check("d_sent", sent_d, 20);
        check("d_seqw", ifd.o_seq, 4);
        check("d_stall", stall_d, 0);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("d2_sent", sent_d, 0);
        check("d2_done", done_d, 0);
        check("d2_val", ifd.o_data_val, 1);
        check("d2_seq", ifd.o_seq, 0);
        check("d2_pay", ifd.o_payload, ld);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
